cpu_run_controller: RTL and testbench

//  Run-control sequencer for the single-cycle CPU: holds the core in reset at boot, gates its

---
 rtl/cpu_ctrl_pkg.sv | 21 ++
 rtl/run_cycle_counter.sv | 33 +++
 rtl/cpu_run_controller.sv | 116 +++++++++++
 tb/tb_cpu_run_controller.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU run controller: FSM states,
// sticky error flag bit positions and the default halt instruction word.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BOOT = 2'd1,
      ST_RUN  = 2'd2,
      ST_HALT = 2'd3
   } state_e;

   localparam int FLG_ZERO  = 0;
   localparam int FLG_NUM   = 1;
   localparam int FLG_AOVF  = 2;
   localparam int FLG_MIS   = 3;
   localparam int FLG_TMO   = 4;
   localparam int NUM_FLAGS = 5;

   localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating retired-instruction counter with synchronous clear and a
// terminal-count compare used as the watchdog trip.
module run_cycle_counter #(
   parameter int              CNT_W = 32,
   parameter longint unsigned LIMIT = 1000000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             term_o
);

   localparam logic [CNT_W-1:0] MAX_VAL = '1;
   // A limit the counter can never represent must never trip.
   localparam bit LIMIT_FITS = (CNT_W >= 64) || (LIMIT < (64'd1 << CNT_W));

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         r_cnt <= '0;
      else if (clr_i)
         r_cnt <= '0;
      else if (en_i && (r_cnt != MAX_VAL))
         r_cnt <= r_cnt + CNT_W'(1);
   end

   assign cnt_o  = r_cnt;
   assign term_o = LIMIT_FITS && (r_cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/cpu_run_controller.sv
// Run-control sequencer for the single-cycle CPU: boot reset hold, per-cycle
// commit gating, and halt on fatal error, halt instruction, request or watchdog.
module cpu_run_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned     BOOT_CYCLES = 2,
   parameter int              CNT_W       = 32,
   parameter longint unsigned MAX_CYCLES  = 1000000,
   parameter logic [31:0]     HALT_INSTR  = HALT_INSTR_DEF,
   parameter logic [3:0]      FATAL_MASK  = 4'b1100
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 halt_req_i,
   input  logic [31:0]          pc_i,
   input  logic [31:0]          instr_i,
   input  logic                 err_zero_i,
   input  logic                 err_num_i,
   input  logic                 addr_ovf_i,
   input  logic                 misalign_i,
   output logic                 cpu_rst_o,
   output logic                 cpu_run_o,
   output logic [1:0]           state_o,
   output logic [CNT_W-1:0]     cycle_cnt_o,
   output logic [NUM_FLAGS-1:0] err_flags_o,
   output logic [31:0]          err_pc_o,
   output logic                 halted_o
);

   localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

   state_e                 r_state, w_next;
   logic [BW-1:0]          r_boot;
   logic [NUM_FLAGS-1:0]   r_flags;
   logic [31:0]            r_err_pc;
   logic [3:0]             w_err;
   logic                   w_fatal, w_halt_ins, w_timeout, w_stop, w_enter_boot;

   assign w_err        = {misalign_i, addr_ovf_i, err_num_i, err_zero_i};
   assign w_fatal      = |(FATAL_MASK & w_err);
   assign w_halt_ins   = (instr_i == HALT_INSTR);
   assign w_stop       = w_fatal | w_halt_ins | w_timeout;
   assign w_enter_boot = (w_next == ST_BOOT) && (r_state != ST_BOOT);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      cpu_rst_o = 1'b0;
      cpu_run_o = 1'b0;
      halted_o  = 1'b0;
      case (r_state)
         ST_IDLE: if (start_i) w_next = ST_BOOT;
         ST_BOOT: if (r_boot == '0) w_next = ST_RUN;
         ST_RUN: begin
            cpu_rst_o = 1'b1;
            cpu_run_o = ~w_stop;
            // A halt request lets the current instruction retire first.
            if (w_stop || halt_req_i) w_next = ST_HALT;
         end
         ST_HALT: begin
            cpu_rst_o = 1'b1;
            halted_o  = 1'b1;
            if (start_i) w_next = ST_BOOT;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         r_boot <= '0;
      else if (w_enter_boot)
         r_boot <= BW'(BOOT_CYCLES - 1);
      else if ((r_state == ST_BOOT) && (r_boot != '0))
         r_boot <= r_boot - BW'(1);
   end

   // Sticky error flags and halt PC; errors outside RUN are ignored.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_flags  <= '0;
         r_err_pc <= '0;
      end else if (w_enter_boot) begin
         r_flags  <= '0;
         r_err_pc <= '0;
      end else if (r_state == ST_RUN) begin
         r_flags <= r_flags | {w_timeout, w_err};
         if (w_stop)
            r_err_pc <= pc_i;
         else if (halt_req_i)
            r_err_pc <= pc_i + 32'd4;
      end
   end

   run_cycle_counter #(
      .CNT_W (CNT_W),
      .LIMIT (MAX_CYCLES)
   ) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (w_enter_boot),
      .en_i   (cpu_run_o),
      .cnt_o  (cycle_cnt_o),
      .term_o (w_timeout)
   );

   assign state_o     = r_state;
   assign err_flags_o = r_flags;
   assign err_pc_o    = r_err_pc;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: directed scenarios plus randomized traffic
// checked against a behavioural reference model.
module tb_cpu_run_controller;

   localparam int              BOOT = 2;
   localparam longint unsigned MAXC = 30;
   localparam logic [31:0]     HI   = 32'hFFFF_FFFF;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, hreq = 1'b0;
   logic [31:0] pc = '0, instr = '0;
   logic        ez = 1'b0, en = 1'b0, ao = 1'b0, mi = 1'b0;
   logic        cpu_rst, cpu_run, halted;
   logic [1:0]  state;
   logic [31:0] cnt, epc;
   logic [4:0]  flags;

   int n_chk = 0, n_fail = 0;

   // reference model
   int              m_state, m_boot;
   longint unsigned m_cnt;
   logic [4:0]      m_flags;
   logic [31:0]     m_pc;

   always #5 clk = ~clk;

   cpu_run_controller #(
      .BOOT_CYCLES (BOOT),
      .CNT_W       (32),
      .MAX_CYCLES  (MAXC),
      .HALT_INSTR  (HI),
      .FATAL_MASK  (4'b1100)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .start_i     (start),
      .halt_req_i  (hreq),
      .pc_i        (pc),
      .instr_i     (instr),
      .err_zero_i  (ez),
      .err_num_i   (en),
      .addr_ovf_i  (ao),
      .misalign_i  (mi),
      .cpu_rst_o   (cpu_rst),
      .cpu_run_o   (cpu_run),
      .state_o     (state),
      .cycle_cnt_o (cnt),
      .err_flags_o (flags),
      .err_pc_o    (epc),
      .halted_o    (halted)
   );

   // misalign and addr_ovf are the fatal ones; halt word and watchdog also stop
   function automatic bit m_stopping();
      return mi || ao || (instr == HI) || (m_cnt == MAXC);
   endfunction

   function automatic bit m_run();
      return (m_state == 2) && !m_stopping();
   endfunction

   task automatic model_reset();
      m_state = 0; m_boot = 0; m_cnt = 0; m_flags = '0; m_pc = '0;
   endtask

   task automatic model_boot();
      m_state = 1; m_boot = BOOT; m_cnt = 0; m_flags = '0; m_pc = '0;
   endtask

   task automatic model_edge();
      bit stop;
      if (!rst_n) begin
         model_reset();
      end else begin
         case (m_state)
            0: if (start) model_boot();
            1: begin
               m_boot = m_boot - 1;
               if (m_boot == 0) m_state = 2;
            end
            2: begin
               stop = m_stopping();
               m_flags = m_flags | {m_cnt == MAXC, mi, ao, en, ez};
               if (!stop && m_cnt != 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
               if (stop) begin
                  m_state = 3; m_pc = pc;
               end else if (hreq) begin
                  m_state = 3; m_pc = pc + 32'd4;
               end
            end
            default: if (start) model_boot();
         endcase
      end
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      start = 0; hreq = 0; instr = '0; ez = 0; en = 0; ao = 0; mi = 0;
   endtask

   task automatic restart();
      start = 1; cyc(); start = 0; cyc(); cyc();
   endtask

   task automatic test_reset();
      cyc(); cyc();
      n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
      n_chk++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_rst: got %b want 0", cpu_rst); end
      n_chk++; if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_run: got %b want 0", cpu_run); end
      n_chk++; if (cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
      n_chk++; if (flags !== 5'd0) begin n_fail++; $display("FAIL reset_flags: got %b want 0", flags); end
      n_chk++; if (epc !== 32'd0) begin n_fail++; $display("FAIL reset_epc: got %h want 0", epc); end
      n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
      rst_n = 1; cyc();
      n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL idle_hold: got %0d want 0", state); end
   endtask

   task automatic test_boot();
      start = 1; cyc(); start = 0;
      n_chk++; if (state !== 2'd1 || cpu_rst !== 1'b0) begin n_fail++; $display("FAIL boot_c1: got st %0d rst %b want 1/0", state, cpu_rst); end
      cyc();
      n_chk++; if (state !== 2'd1 || cpu_rst !== 1'b0) begin n_fail++; $display("FAIL boot_c2: got st %0d rst %b want 1/0", state, cpu_rst); end
      cyc();
      n_chk++; if (state !== 2'd2 || cpu_rst !== 1'b1 || cpu_run !== 1'b1) begin n_fail++; $display("FAIL boot_run: got st %0d rst %b run %b want 2/1/1", state, cpu_rst, cpu_run); end
   endtask

   task automatic test_fatal();
      pc = 32'h40; mi = 1; #1;
      n_chk++; if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL fatal_run: got %b want 0", cpu_run); end
      cyc(); mi = 0;
      n_chk++; if (state !== 2'd3 || halted !== 1'b1) begin n_fail++; $display("FAIL fatal_state: got %0d/%b want 3/1", state, halted); end
      n_chk++; if (flags !== 5'b01000) begin n_fail++; $display("FAIL fatal_flags: got %b want 01000", flags); end
      n_chk++; if (epc !== 32'h40) begin n_fail++; $display("FAIL fatal_epc: got %h want 40", epc); end
      n_chk++; if (cnt !== 32'd0 || cpu_rst !== 1'b1) begin n_fail++; $display("FAIL fatal_cnt: got %0d rst %b want 0/1", cnt, cpu_rst); end
   endtask

   task automatic test_masked();
      restart();
      n_chk++; if (flags !== 5'd0 || epc !== 32'd0 || cnt !== 32'd0) begin n_fail++; $display("FAIL restart_clear: got %b %h %0d want 0", flags, epc, cnt); end
      pc = 32'h10; en = 1; #1;
      n_chk++; if (cpu_run !== 1'b1) begin n_fail++; $display("FAIL masked_run: got %b want 1", cpu_run); end
      cyc(); en = 0;
      n_chk++; if (flags !== 5'b00010 || state !== 2'd2) begin n_fail++; $display("FAIL masked_flags: got %b st %0d want 00010/2", flags, state); end
      pc = 32'h14; cyc();
      n_chk++; if (cnt !== 32'd2) begin n_fail++; $display("FAIL masked_cnt: got %0d want 2", cnt); end
   endtask

   task automatic test_halt_req();
      pc = 32'h18; hreq = 1; #1;
      n_chk++; if (cpu_run !== 1'b1) begin n_fail++; $display("FAIL hreq_run: got %b want 1", cpu_run); end
      cyc(); hreq = 0;
      n_chk++; if (state !== 2'd3 || epc !== 32'h1C || cnt !== 32'd3) begin n_fail++; $display("FAIL hreq_halt: got st %0d epc %h cnt %0d want 3/1c/3", state, epc, cnt); end
      hreq = 1; mi = 1; cyc(); cyc(); clear_in();
      n_chk++; if (state !== 2'd3 || flags !== 5'b00010 || epc !== 32'h1C) begin n_fail++; $display("FAIL halt_ignore: got st %0d fl %b epc %h", state, flags, epc); end
   endtask

   task automatic test_halt_instr();
      restart();
      for (int i = 0; i < 11; i++) begin pc = 32'(4 * i); cyc(); end
      pc = 32'h2C; instr = HI; #1;
      n_chk++; if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL hinstr_run: got %b want 0", cpu_run); end
      cyc(); instr = '0;
      n_chk++; if (state !== 2'd3 || cnt !== 32'd11 || epc !== 32'h2C || flags !== 5'd0) begin n_fail++; $display("FAIL hinstr: got st %0d cnt %0d epc %h fl %b", state, cnt, epc, flags); end
   endtask

   task automatic test_watchdog();
      restart();
      for (int i = 0; i < 30; i++) begin pc = 32'(4 * i); cyc(); end
      n_chk++; if (cnt !== 32'd30 || state !== 2'd2 || cpu_run !== 1'b0) begin n_fail++; $display("FAIL wd_pre: got cnt %0d st %0d run %b", cnt, state, cpu_run); end
      cyc();
      n_chk++; if (state !== 2'd3 || flags !== 5'b10000 || cnt !== 32'd30) begin n_fail++; $display("FAIL wd_halt: got st %0d fl %b cnt %0d", state, flags, cnt); end
   endtask

   task automatic test_simultaneous();
      restart();
      pc = 32'h80; instr = HI; ao = 1; ez = 1; en = 1; cyc(); clear_in();
      n_chk++; if (flags !== 5'b00111 || epc !== 32'h80 || state !== 2'd3 || cnt !== 32'd0) begin n_fail++; $display("FAIL simul: got fl %b epc %h st %0d cnt %0d", flags, epc, state, cnt); end
      start = 1; cyc(); cyc(); cyc();
      n_chk++; if (state !== 2'd2) begin n_fail++; $display("FAIL start_in_boot: got %0d want 2", state); end
      cyc(); start = 0;
      n_chk++; if (state !== 2'd2 || cnt !== 32'd1) begin n_fail++; $display("FAIL start_in_run: got st %0d cnt %0d want 2/1", state, cnt); end
   endtask

   task automatic test_reset_midrun();
      ez = 1; cyc(); ez = 0;
      #2 rst_n = 0; #1;
      n_chk++; if (state !== 2'd0 || cpu_rst !== 1'b0 || cpu_run !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL midrst_ctl: got st %0d rst %b run %b"
         , state, cpu_rst, cpu_run); end
      n_chk++; if (cnt !== 32'd0 || flags !== 5'd0 || epc !== 32'd0) begin n_fail++; $display("FAIL midrst_data: got cnt %0d fl %b epc %h", cnt, flags, epc); end
      cyc(); rst_n = 1; cyc();
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         start = ($urandom_range(0, 9) == 0);
         hreq  = ($urandom_range(0, 29) == 0);
         ez    = ($urandom_range(0, 24) == 0);
         en    = ($urandom_range(0, 24) == 0);
         ao    = ($urandom_range(0, 39) == 0);
         mi    = ($urandom_range(0, 39) == 0);
         instr = ($urandom_range(0, 24) == 0) ? HI : $urandom;
         pc    = $urandom & 32'hFFFF_FFFC;
         rst_n = ($urandom_range(0, 149) != 0);
         if (!rst_n) model_reset();
         @(negedge clk);
         n_chk++; if (state !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state[%0d]: got %0d want %0d", i, state, m_state); end
         n_chk++; if (cpu_rst !== (m_state >= 2)) begin n_fail++; $display("FAIL rnd_cpu_rst[%0d]: got %b", i, cpu_rst); end
         n_chk++; if (cpu_run !== m_run()) begin n_fail++; $display("FAIL rnd_cpu_run[%0d]: got %b want %b", i, cpu_run, m_run()); end
         n_chk++; if (cnt !== 32'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, cnt, m_cnt); end
         n_chk++; if (flags !== m_flags) begin n_fail++; $display("FAIL rnd_flags[%0d]: got %b want %b", i, flags, m_flags); end
         n_chk++; if (epc !== m_pc) begin n_fail++; $display("FAIL rnd_epc[%0d]: got %h want %h", i, epc, m_pc); end
         n_chk++; if (halted !== (m_state == 3)) begin n_fail++; $display("FAIL rnd_halted[%0d]: got %b", i, halted); end
         cyc();
      end
      clear_in(); rst_n = 1;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_boot();
      test_fatal();
      test_masked();
      test_halt_req();
      test_halt_instr();
      test_watchdog();
      test_simultaneous();
      test_reset_midrun();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
